// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge filter: two on-chip line buffers, raster framing,
// two-stage pipeline (window register, then magnitude register).
module sobel_stream #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] in_pixel,
   input  logic [1:0]       mode,
   input  logic [PIX_W-1:0] thresh,
   output logic             out_valid,
   output logic             out_sof,
   output logic             out_eol,
   output logic [PIX_W-1:0] out_pixel
);

   localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int unsigned SW    = PIX_W + 3;
   localparam int unsigned AW    = PIX_W + 2;
   localparam logic [PIX_W-1:0] PIX_MAX = '1;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                  state_q, state_d;
   logic [COL_W-1:0]        col_q, col_d;
   logic [ROW_W-1:0]        row_q, row_d;

   // Column history: index 0 = top row (r-2), 1 = middle (r-1), 2 = bottom (r)
   logic [2:0][PIX_W-1:0]   col1_q, col1_d;
   logic [2:0][PIX_W-1:0]   col2_q, col2_d;

   // Window without the centre tap: p0 p1 p2 p3 p5 p6 p7 p8 in slots 0..7
   logic [7:0][PIX_W-1:0]   s1_win_q, s1_win_d;
   logic                    s1_valid_q, s1_valid_d;
   logic                    s1_sof_q, s1_sof_d;
   logic                    s1_eol_q, s1_eol_d;
   logic [1:0]              s1_mode_q, s1_mode_d;
   logic [PIX_W-1:0]        s1_thresh_q, s1_thresh_d;

   logic                    out_valid_q, out_valid_d;
   logic                    out_sof_q, out_sof_d;
   logic                    out_eol_q, out_eol_d;
   logic [PIX_W-1:0]        out_pixel_q, out_pixel_d;

   logic [PIX_W-1:0]        lb_top_q [IMG_W];
   logic [PIX_W-1:0]        lb_mid_q [IMG_W];

   logic                    accept_c;
   logic                    complete_c;
   logic                    last_col_c;
   logic                    last_row_c;
   logic [COL_W-1:0]        pos_col_c;
   logic [ROW_W-1:0]        pos_row_c;
   logic [2:0][PIX_W-1:0]   cur_col_c;

   logic signed [SW-1:0]    e0, e1, e2, e3, e5, e6, e7, e8;
   logic signed [SW-1:0]    gx, gy;
   logic [AW-1:0]           ax, ay, mx;
   logic [SW-1:0]           l1;
   logic [PIX_W-1:0]        l1_sat, mx_sat, mag;

   // Framing FSM, raster counters, column history and window capture
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      col1_d      = col1_q;
      col2_d      = col2_q;
      s1_win_d    = s1_win_q;
      s1_mode_d   = s1_mode_q;
      s1_thresh_d = s1_thresh_q;

      accept_c   = in_valid & (in_sof | (state_q == ACTIVE));
      pos_col_c  = in_sof ? '0 : col_q;
      pos_row_c  = in_sof ? '0 : row_q;
      last_col_c = (pos_col_c == COL_W'(IMG_W - 1));
      last_row_c = (pos_row_c == ROW_W'(IMG_H - 1));
      cur_col_c  = {in_pixel, lb_mid_q[pos_col_c], lb_top_q[pos_col_c]};
      complete_c = accept_c && (pos_row_c >= ROW_W'(2)) && (pos_col_c >= COL_W'(2));

      if (accept_c) begin
         state_d = ACTIVE;
         col1_d  = cur_col_c;
         col2_d  = col1_q;
         if (last_col_c) begin
            col_d = '0;
            if (last_row_c) begin
               row_d   = '0;
               state_d = IDLE;
            end else begin
               row_d = pos_row_c + ROW_W'(1);
            end
         end else begin
            col_d = pos_col_c + COL_W'(1);
            row_d = pos_row_c;
         end
      end

      s1_valid_d = complete_c;
      s1_sof_d   = complete_c && (pos_row_c == ROW_W'(2)) && (pos_col_c == COL_W'(2));
      s1_eol_d   = complete_c && last_col_c;
      if (complete_c) begin
         s1_win_d    = {cur_col_c[2], col1_q[2], col2_q[2], cur_col_c[1],
                        col2_q[1], cur_col_c[0], col1_q[0], col2_q[0]};
         s1_mode_d   = mode;
         s1_thresh_d = thresh;
      end
   end

   // Gradient magnitude and output mode selection
   always_comb begin
      e0 = $signed(SW'(s1_win_q[0]));
      e1 = $signed(SW'(s1_win_q[1]));
      e2 = $signed(SW'(s1_win_q[2]));
      e3 = $signed(SW'(s1_win_q[3]));
      e5 = $signed(SW'(s1_win_q[4]));
      e6 = $signed(SW'(s1_win_q[5]));
      e7 = $signed(SW'(s1_win_q[6]));
      e8 = $signed(SW'(s1_win_q[7]));

      gx = (e2 - e0) + ((e5 - e3) <<< 1) + (e8 - e6);
      gy = (e0 - e6) + ((e1 - e7) <<< 1) + (e2 - e8);
      ax = gx[SW-1] ? AW'(-gx) : AW'(gx);
      ay = gy[SW-1] ? AW'(-gy) : AW'(gy);

      l1     = SW'(ax) + SW'(ay);
      l1_sat = (l1 > SW'(PIX_MAX)) ? PIX_MAX : PIX_W'(l1);
      mx     = (ax >= ay) ? ax : ay;
      mx_sat = (mx > AW'(PIX_MAX)) ? PIX_MAX : PIX_W'(mx);

      case (s1_mode_q)
         2'b01:   mag = mx_sat;
         2'b10:   mag = (l1_sat >= s1_thresh_q) ? PIX_MAX : '0;
         default: mag = l1_sat;
      endcase

      out_valid_d = s1_valid_q;
      out_sof_d   = s1_valid_q & s1_sof_q;
      out_eol_d   = s1_valid_q & s1_eol_q;
      out_pixel_d = s1_valid_q ? mag : '0;
   end

   // Two line buffers; contents need no reset
   always_ff @(posedge clk) begin
      if (accept_c) begin
         lb_top_q[pos_col_c] <= lb_mid_q[pos_col_c];
         lb_mid_q[pos_col_c] <= in_pixel;
      end
   end

   // State, counters and pipeline registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         col1_q      <= '0;
         col2_q      <= '0;
         s1_win_q    <= '0;
         s1_valid_q  <= 1'b0;
         s1_sof_q    <= 1'b0;
         s1_eol_q    <= 1'b0;
         s1_mode_q   <= '0;
         s1_thresh_q <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eol_q   <= 1'b0;
         out_pixel_q <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         col1_q      <= col1_d;
         col2_q      <= col2_d;
         s1_win_q    <= s1_win_d;
         s1_valid_q  <= s1_valid_d;
         s1_sof_q    <= s1_sof_d;
         s1_eol_q    <= s1_eol_d;
         s1_mode_q   <= s1_mode_d;
         s1_thresh_q <= s1_thresh_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_eol_q   <= out_eol_d;
         out_pixel_q <= out_pixel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sof   = out_sof_q;
   assign out_eol   = out_eol_q;
   assign out_pixel = out_pixel_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream on an 8x6 frame.
module tb_sobel_stream;

   localparam int W = 8;
   localparam int H = 6;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_sof;
   logic [7:0] in_pixel;
   logic [1:0] mode;
   logic [7:0] thresh;
   logic       out_valid;
   logic       out_sof;
   logic       out_eol;
   logic [7:0] out_pixel;

   sobel_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
      .in_pixel(in_pixel), .mode(mode), .thresh(thresh),
      .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
      .out_pixel(out_pixel)
   );

   typedef struct {
      int pix;
      bit sof;
      bit eol;
      int due;
   } exp_t;

   exp_t sb[$];
   int   img [H][W];
   bit   m_active;
   int   m_r, m_c;
   int   cyc;
   int   tests, fails;
   int   n_out, n_sof, n_eol;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int model(int r, int c, int m, int th);
      int w[9];
      int gx, gy, ax, ay, l1, mx, l1s, mxs;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[i*3+j] = img[r-2+i][c-2+j];
      gx  = (w[2] - w[0]) + 2 * (w[5] - w[3]) + (w[8] - w[6]);
      gy  = (w[0] - w[6]) + 2 * (w[1] - w[7]) + (w[2] - w[8]);
      ax  = (gx < 0) ? -gx : gx;
      ay  = (gy < 0) ? -gy : gy;
      l1  = ax + ay;
      mx  = (ax > ay) ? ax : ay;
      l1s = (l1 > 255) ? 255 : l1;
      mxs = (mx > 255) ? 255 : mx;
      if (m == 1) return mxs;
      if (m == 2) return (l1s >= th) ? 255 : 0;
      return l1s;
   endfunction

   function automatic int pat(int kind, int r, int c);
      if (kind == 0) return 100;
      if (kind == 1) return (c < 4) ? 0 : 255;
      return 10 * c + 20 * r;
   endfunction

   // One input cycle; the scoreboard receives the expected output of any completing beat
   task automatic beat(input bit v, input bit sof, input int px, input int m, input int th);
      exp_t e;
      in_valid = v;
      in_sof   = sof;
      in_pixel = 8'(px);
      mode     = 2'(m);
      thresh   = 8'(th);
      if (v) begin
         if (sof) begin
            m_active = 1'b1;
            m_r = 0;
            m_c = 0;
         end
         if (m_active) begin
            img[m_r][m_c] = px;
            if (m_r >= 2 && m_c >= 2) begin
               e.pix = model(m_r, m_c, m, th);
               e.sof = ((m_r - 1) == 1) && ((m_c - 1) == 1);
               e.eol = ((m_c - 1) == W - 2);
               e.due = cyc + 2;
               sb.push_back(e);
            end
            if (m_c == W - 1) begin
               m_c = 0;
               if (m_r == H - 1) begin
                  m_r = 0;
                  m_active = 1'b0;
               end else m_r++;
            end else m_c++;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_beats(input int kind, input int m, input int th, input bit gaps,
                             input bit vary, input int first, input int last);
      int mm, tt;
      for (int k = first; k < last; k++) begin
         if (gaps) repeat ($urandom_range(0, 2)) beat(1'b0, 1'b0, 0, m, th);
         mm = vary ? (k % 4) : m;
         tt = vary ? (((k % 2) == 1) ? 200 : 241) : th;
         beat(1'b1, k == 0, pat(kind, k / W, k % W), mm, tt);
      end
   endtask

   task automatic send_frame(input int kind, input int m, input int th, input bit gaps, input bit vary);
      send_beats(kind, m, th, gaps, vary, 0, W * H);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (sb.size() > 0 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_drain_timeout"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic clr_counts();
      n_out = 0;
      n_sof = 0;
      n_eol = 0;
   endtask

   // Output monitor: pop and compare on every out_valid, flag missing outputs
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (out_valid) begin
            n_out++;
            if (out_sof) n_sof++;
            if (out_eol) n_eol++;
            if (sb.size() == 0) begin
               check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("out_pixel", 32'(out_pixel), 32'(e.pix));
               check("out_sof", 32'(out_sof), 32'(e.sof));
               check("out_eol", 32'(out_eol), 32'(e.eol));
               check("latency", 32'(cyc), 32'(e.due));
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("missing_out_valid", 32'd0, 32'd1);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      fails = 0;
      m_active = 1'b0;
      m_r = 0;
      m_c = 0;
      clr_counts();
      rst = 1'b1;
      in_valid = 1'b0;
      in_sof = 1'b0;
      in_pixel = '0;
      mode = '0;
      thresh = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_sof", 32'(out_sof), 32'd0);
      check("reset_out_eol", 32'(out_eol), 32'd0);
      check("reset_out_pixel", 32'(out_pixel), 32'd0);

      // Flat frame
      clr_counts();
      send_frame(0, 0, 0, 1'b0, 1'b0);
      drain("flat");
      check("flat_count", 32'(n_out), 32'd24);
      check("flat_sof_count", 32'(n_sof), 32'd1);
      check("flat_eol_count", 32'(n_eol), 32'd4);

      // Vertical step edge, saturating
      clr_counts();
      send_frame(1, 0, 0, 1'b0, 1'b0);
      drain("step");
      check("step_count", 32'(n_out), 32'd24);

      // Ramp in each mode, then mode/thresh changing on every beat
      send_frame(2, 0, 0, 1'b0, 1'b0);
      send_frame(2, 1, 0, 1'b0, 1'b0);
      send_frame(2, 2, 200, 1'b0, 1'b0);
      send_frame(2, 2, 241, 1'b0, 1'b0);
      send_frame(2, 0, 0, 1'b0, 1'b1);
      drain("ramp");

      // Step edge with random input gaps
      clr_counts();
      send_frame(1, 0, 0, 1'b1, 1'b0);
      drain("gaps");
      check("gaps_count", 32'(n_out), 32'd24);

      // Dropped beats in IDLE, then abort with in_sof at (3,5)
      clr_counts();
      repeat (3) beat(1'b1, 1'b0, 77, 0, 0);
      send_beats(2, 0, 0, 1'b0, 1'b0, 0, 3 * W + 5);
      send_frame(1, 0, 0, 1'b0, 1'b0);
      drain("abort");
      check("abort_count", 32'(n_out), 32'd33);
      check("abort_sof_count", 32'(n_sof), 32'd2);

      // Synchronous reset on the (4,2) beat
      send_beats(2, 0, 0, 1'b0, 1'b0, 0, 4 * W + 2);
      rst = 1'b1;
      in_valid = 1'b1;
      in_pixel = 8'd123;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      m_active = 1'b0;
      m_r = 0;
      m_c = 0;
      check("rst_mid_out_valid", 32'(out_valid), 32'd0);
      check("rst_mid_out_sof", 32'(out_sof), 32'd0);
      check("rst_mid_out_eol", 32'(out_eol), 32'd0);
      check("rst_mid_out_pixel", 32'(out_pixel), 32'd0);
      clr_counts();
      for (int k = 4 * W + 3; k < W * H; k++) beat(1'b1, 1'b0, 200, 0, 0);
      repeat (5) @(posedge clk);
      #1;
      check("rst_no_output", 32'(n_out), 32'd0);
      send_frame(1, 0, 0, 1'b0, 1'b0);
      drain("post_rst");
      check("post_rst_count", 32'(n_out), 32'd24);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
